// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        RELEASE,
        RUN,
        FAULT
    } boot_state_t;

    localparam int HDR_BYTES = 4;

    // Reserved for a future signed-image header; the loader does not check it yet.
    localparam logic [31:0] BOOT_MAGIC = 32'hB007_10AD;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs four accepted bytes into one little-endian word
module byte_assembler
    import boot_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  count_q;
    logic [23:0] shift_q;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            count_q <= 2'd0;
            shift_q <= 24'd0;
        end else if (valid) begin
            count_q <= count_q + 2'd1;
            shift_q <= {data, shift_q[23:8]};
        end
    end

    // The completed word includes the byte being accepted this cycle.
    assign word      = {data, shift_q};
    assign word_done = valid && (count_q == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads a boot image into RAM, then releases the CPU
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 30,
    parameter int MEM_WORDS = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_data_w,
    input  logic [3:0]        cpu_mask_w,
    input  logic              cpu_write,
    output logic [31:0]       cpu_data_r,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_w,
    output logic [3:0]        mem_mask_w,
    output logic              mem_write,
    input  logic [31:0]       mem_data_r,
    output logic              busy,
    output logic              fault,
    output logic [31:0]       words_loaded
);

    boot_state_t state_q, state_d;

    logic              accept;
    logic [31:0]       word;
    logic              word_done;
    logic [31:0]       count_q;
    logic [31:0]       words_loaded_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [31:0]       ld_data_q;
    logic [3:0]        ld_mask_q;
    logic              ld_write_q;
    logic              run;

    assign rx_ready = reset && (state_q == HDR || state_q == DATA) && !load_req;
    assign accept   = rx_valid && rx_ready;

    byte_assembler u_byte_assembler (
        .clock     (clock),
        .resetn    (reset),
        .clear     (load_req),
        .valid     (accept),
        .data      (rx_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_req) begin
            state_d = HDR;
        end else begin
            case (state_q)
                HDR: begin
                    if (word_done) begin
                        if (word == 32'd0)                  state_d = RELEASE;
                        else if (word > 32'(MEM_WORDS))     state_d = FAULT;
                        else                                state_d = DATA;
                    end
                end
                // Leave once the write of the final word is on the bus.
                DATA:    if (ld_write_q && words_loaded_q == count_q) state_d = RELEASE;
                RELEASE: state_d = RUN;
                RUN:     state_d = RUN;
                FAULT:   state_d = FAULT;
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || load_req) begin
            count_q        <= 32'd0;
            words_loaded_q <= 32'd0;
            ld_addr_q      <= '0;
            ld_data_q      <= 32'd0;
            ld_mask_q      <= 4'd0;
            ld_write_q     <= 1'b0;
        end else begin
            ld_write_q <= 1'b0;
            ld_mask_q  <= 4'd0;
            if (state_q == HDR && word_done) begin
                count_q <= word;
            end
            if (state_q == DATA && word_done) begin
                ld_write_q     <= 1'b1;
                ld_mask_q      <= 4'b1111;
                ld_addr_q      <= ADDR_W'(words_loaded_q);
                ld_data_q      <= word;
                words_loaded_q <= words_loaded_q + 32'd1;
            end
        end
    end

    assign run          = (state_q == RUN);
    assign mem_addr     = run ? cpu_addr   : ld_addr_q;
    assign mem_data_w   = run ? cpu_data_w : ld_data_q;
    assign mem_mask_w   = run ? cpu_mask_w : ld_mask_q;
    assign mem_write    = run ? cpu_write  : ld_write_q;
    assign cpu_data_r   = mem_data_r;
    assign cpu_reset    = !run;
    assign busy         = !run;
    assign fault        = (state_q == FAULT);
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - randomized self-checking bench for boot_sequencer
module tb_boot_sequencer;

    localparam int ADDR_W    = 30;
    localparam int MEM_WORDS = 4096;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              load_req;
    logic              cpu_reset;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_data_w;
    logic [3:0]        cpu_mask_w;
    logic              cpu_write;
    logic [31:0]       cpu_data_r;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_w;
    logic [3:0]        mem_mask_w;
    logic              mem_write;
    logic [31:0]       mem_data_r;
    logic              busy;
    logic              fault;
    logic [31:0]       words_loaded;

    boot_sequencer #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .cpu_reset    (cpu_reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_w   (cpu_data_w),
        .cpu_mask_w   (cpu_mask_w),
        .cpu_write    (cpu_write),
        .cpu_data_r   (cpu_data_r),
        .mem_addr     (mem_addr),
        .mem_data_w   (mem_data_w),
        .mem_mask_w   (mem_mask_w),
        .mem_write    (mem_write),
        .mem_data_r   (mem_data_r),
        .busy         (busy),
        .fault        (fault),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        mask;
        int                c;
    } wr_t;

    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   fall_cyc  = -1;
    int   accept_cyc = 0;
    wr_t  wq[$];
    wr_t  mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    // Loader-side bus traffic and the first cycle the CPU runs.
    always @(negedge clock) begin
        if (mem_write && busy) begin
            mon_e.addr = mem_addr;
            mon_e.data = mem_data_w;
            mon_e.mask = mem_mask_w;
            mon_e.c    = cyc;
            wq.push_back(mon_e);
        end
        if (fall_cyc < 0 && !cpu_reset) fall_cyc = cyc;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n = 0;
        if (stall && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (n >= 100) check("rx_ready_timeout", 0, 1);
        @(posedge clock);
        #1;
        rx_valid   = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] words[$], input bit stall);
        wq.delete();
        fall_cyc = -1;
        send_word(32'(words.size()), stall);
        foreach (words[i]) send_word(words[i], stall);
        repeat (6) tick();
    endtask

    task automatic verify(input string tag, input logic [31:0] words[$]);
        int n = words.size();
        check({tag, "_nwrites"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, "_addr"}, 64'(wq[i].addr), 64'(i));
            check({tag, "_data"}, 64'(wq[i].data), 64'(words[i]));
            check({tag, "_mask"}, 64'(wq[i].mask), 64'hf);
        end
        if (n > 0 && wq.size() > 0) begin
            check({tag, "_wr_latency"}, 64'(wq[wq.size()-1].c), 64'(accept_cyc));
            check({tag, "_release"}, 64'(fall_cyc), 64'(wq[wq.size()-1].c + 2));
        end else if (n == 0) begin
            check({tag, "_release"}, 64'(fall_cyc), 64'(accept_cyc + 1));
        end
        @(negedge clock);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(n));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_mask"}, 64'(mem_mask_w), 64'd0);
        check({tag, "_mem_data"}, 64'(mem_data_w), 64'd0);
        check({tag, "_fault"}, 64'(fault), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] img[$];
        logic [31:0] d;
        logic [31:0] w1;

        reset = 1'b0; rx_data = 8'd0; rx_valid = 1'b1; load_req = 1'b0;
        cpu_addr = '0; cpu_data_w = 32'd0; cpu_mask_w = 4'd0; cpu_write = 1'b0;
        mem_data_r = 32'd0;
        repeat (3) tick();
        @(negedge clock);
        check_reset_values("reset");
        check("reset_rx_ready", 64'(rx_ready), 64'd0);
        tick();
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clock);
        check("hdr_rx_ready", 64'(rx_ready), 64'd1);
        tick();

        // Two-word program from the reference image.
        img = '{32'h0010_0513, 32'h0000_006f};
        load_image(img, 1'b0);
        verify("img2", img);

        // CPU owns the bus in RUN; loader owns it otherwise.
        cpu_addr = 30'd5; cpu_mask_w = 4'b0010; cpu_write = 1'b1;
        cpu_data_w = $urandom; mem_data_r = $urandom;
        @(negedge clock);
        check("run_mem_write", 64'(mem_write), 64'd1);
        check("run_mem_addr", 64'(mem_addr), 64'd5);
        check("run_mem_mask", 64'(mem_mask_w), 64'b0010);
        check("run_mem_data", 64'(mem_data_w), 64'(cpu_data_w));
        check("run_cpu_data_r", 64'(cpu_data_r), 64'(mem_data_r));
        tick();
        pulse_load();
        @(negedge clock);
        check("hdr_mem_write", 64'(mem_write), 64'd0);
        check("hdr_mem_addr", 64'(mem_addr), 64'd0);
        check("hdr_cpu_reset", 64'(cpu_reset), 64'd1);
        check("hdr_words_loaded", 64'(words_loaded), 64'd0);
        tick();
        cpu_write = 1'b0;

        // Empty image releases the CPU straight away.
        img.delete();
        load_image(img, 1'b0);
        verify("empty", img);

        // Oversized image faults until load_req.
        pulse_load();
        send_word(32'(MEM_WORDS + 1), 1'b0);
        rx_valid = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check("fault_flag", 64'(fault), 64'd1);
        check("fault_rx_ready", 64'(rx_ready), 64'd0);
        check("fault_cpu_reset", 64'(cpu_reset), 64'd1);
        check("fault_mem_write", 64'(mem_write), 64'd0);
        tick();
        rx_valid = 1'b0;
        pulse_load();
        @(negedge clock);
        check("unfault_flag", 64'(fault), 64'd0);
        check("unfault_rx_ready", 64'(rx_ready), 64'd1);
        check("unfault_cpu_reset", 64'(cpu_reset), 64'd1);
        tick();

        // Largest legal header is accepted (no fault), then abandoned.
        send_word(32'(MEM_WORDS), 1'b0);
        @(negedge clock);
        check("maxhdr_fault", 64'(fault), 64'd0);
        check("maxhdr_rx_ready", 64'(rx_ready), 64'd1);
        tick();
        pulse_load();

        // Random images with random stalls.
        for (int t = 0; t < 4; t++) begin
            img.delete();
            repeat ($urandom_range(1, 6)) img.push_back($urandom);
            load_image(img, 1'b1);
            verify($sformatf("rand%0d", t), img);
            pulse_load();
        end

        // Abort in the middle of word 1; the 3rd byte collides with load_req.
        wq.delete();
        d  = $urandom;
        w1 = $urandom;
        send_word(32'd3, 1'b1);
        send_word(d, 1'b1);
        send_byte(w1[7:0], 1'b1);
        send_byte(w1[15:8], 1'b1);
        rx_data = w1[23:16]; rx_valid = 1'b1; load_req = 1'b1;
        @(negedge clock);
        check("abort_rx_ready", 64'(rx_ready), 64'd0);
        tick();
        load_req = 1'b0; rx_valid = 1'b0;
        repeat (4) tick();
        check("abort_nwrites", 64'(wq.size()), 64'd1);
        check("abort_words_loaded", 64'(words_loaded), 64'd0);
        check("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        img = '{$urandom, $urandom};
        load_image(img, 1'b1);
        verify("reload", img);

        // Reset arrives while a loader write is on the bus.
        pulse_load();
        send_word(32'd2, 1'b0);
        send_word($urandom, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("rstwr_rx_ready", 64'(rx_ready), 64'd0);
        tick();
        @(negedge clock);
        check_reset_values("rstwr");
        tick();
        reset = 1'b1;
        img = '{$urandom};
        load_image(img, 1'b0);
        verify("post_reset", img);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
